// File: rtl/clk_div_prog.sv
// Programmable clock divider: low phase floor(D/2), high phase D-floor(D/2); divisor changes land on period boundaries.
// Latency: outputs registered, first rise L cycles after en sampled high; no backpressure (div_ld always accepted, last wins).
module clk_div_prog #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 10000
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_ld,
    output logic             clkout,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             ld_ack
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_C = (DEF_DIV < 2) ? TWO : CNT_W'(DEF_DIV);

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_val;
    logic             pend_flg;
    logic [CNT_W-1:0] len_lo;
    logic [CNT_W-1:0] len_hi;
    logic [CNT_W-1:0] lim;
    logic             at_lim;
    logic             apply_now;

    // div_cur is always >= 2, so both phase lengths are >= 1 and lim never underflows.
    assign len_lo    = div_cur >> 1;
    assign len_hi    = div_cur - len_lo;
    assign lim       = clkout ? (len_hi - ONE) : (len_lo - ONE);
    assign at_lim    = (cnt == lim);
    assign apply_now = pend_flg && (!en || (at_lim && !clkout));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clkout    <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            ld_ack    <= 1'b0;
            div_cur   <= DEF_C;
            pend_val  <= DEF_C;
            pend_flg  <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            ld_ack    <= 1'b0;

            if (!en) begin
                cnt       <= '0;
                clkout    <= 1'b0;
                fall_tick <= clkout;
            end else if (!at_lim) begin
                cnt <= cnt + ONE;
            end else begin
                cnt       <= '0;
                clkout    <= ~clkout;
                rise_tick <= ~clkout;
                fall_tick <= clkout;
            end

            if (apply_now) begin
                div_cur  <= pend_val;
                pend_flg <= 1'b0;
                ld_ack   <= 1'b1;
            end

            // A load in the apply cycle re-arms the pending slot after the old value moved out.
            if (div_ld) begin
                pend_val <= clamp(div_in);
                pend_flg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog at default parameters: phase lengths, loads, enable and reset behaviour.
module tb_clk_div_prog;

    localparam int CNT_W = 16;

    logic             clkin = 1'b0;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_ld;
    logic             clkout;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] div_cur;
    logic             ld_ack;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(10000)) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .div_ld    (div_ld),
        .clkout    (clkout),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .div_cur   (div_cur),
        .ld_ack    (ld_ack)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic do_ld(input int v);
        div_in = CNT_W'(v);
        div_ld = 1'b1;
        tick();
        div_ld = 1'b0;
    endtask

    // Ticks until clkout reaches lvl; returns the number of edges taken.
    task automatic wait_level(input logic lvl, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (clkout !== lvl && cnt < 20000);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        div_in = '0;
        div_ld = 1'b0;
        repeat (2) tick();
        check("rst_clkout", clkout, 0);
        check("rst_rise", rise_tick, 0);
        check("rst_fall", fall_tick, 0);
        check("rst_ack", ld_ack, 0);
        check("rst_div", div_cur, 10000);

        // Default divisor: 5000 low, 5000 high.
        rst_n = 1'b1;
        en    = 1'b1;
        wait_level(1'b1, n);
        check("def_low", n, 5000);
        check("def_rise", rise_tick, 1);
        tick();
        check("def_rise_1cyc", rise_tick, 0);
        wait_level(1'b0, n);
        check("def_high", n + 1, 5000);
        check("def_fall", fall_tick, 1);

        // D=5 loaded mid-low: old period finishes, then 3 high / 2 low.
        repeat (100) tick();
        do_ld(5);
        check("d5_not_yet", div_cur, 10000);
        wait_level(1'b1, n);
        check("d5_old_low", n, 4899);
        check("d5_ack", ld_ack, 1);
        check("d5_div", div_cur, 5);
        wait_level(1'b0, n);
        check("d5_high", n, 3);
        check("d5_ack_clear", ld_ack, 0);
        wait_level(1'b1, n);
        check("d5_low", n, 2);
        wait_level(1'b0, n);
        check("d5_high2", n, 3);

        // D=0 and D=1 both clamp to 2.
        do_ld(0);
        wait_level(1'b1, n);
        check("d0_low", n + 1, 2);
        check("d0_ack", ld_ack, 1);
        check("d0_div", div_cur, 2);
        wait_level(1'b0, n);
        check("d0_high", n, 1);
        wait_level(1'b1, n);
        check("d0_low2", n, 1);
        do_ld(1);
        check("d1_fell", clkout, 0);
        wait_level(1'b1, n);
        check("d1_low", n, 1);
        check("d1_ack", ld_ack, 1);
        check("d1_div", div_cur, 2);

        // Move to D=20 so loads can stack inside one low phase.
        do_ld(20);
        wait_level(1'b1, n);
        check("d20_ack", ld_ack, 1);
        check("d20_div", div_cur, 20);
        wait_level(1'b0, n);
        check("d20_high", n, 10);

        // 8 then 12 pending; 6 loaded on the apply edge itself.
        do_ld(8);
        do_ld(12);
        check("last_win_hold", div_cur, 20);
        repeat (7) tick();
        check("pre_apply_low", clkout, 0);
        do_ld(6);
        check("apply_rise", clkout, 1);
        check("apply_ack", ld_ack, 1);
        check("apply_div12", div_cur, 12);
        wait_level(1'b0, n);
        check("d12_high", n, 6);
        check("d12_fall_noack", ld_ack, 0);
        wait_level(1'b1, n);
        check("d12_low", n, 6);
        check("d6_ack", ld_ack, 1);
        check("d6_div", div_cur, 6);
        wait_level(1'b0, n);
        check("d6_high", n, 3);

        // Drop en in the high phase, load while disabled, re-enable.
        wait_level(1'b1, n);
        check("d6_low", n, 3);
        tick();
        en = 1'b0;
        tick();
        check("dis_clkout", clkout, 0);
        check("dis_fall", fall_tick, 1);
        tick();
        check("dis_fall_1cyc", fall_tick, 0);
        do_ld(9);
        tick();
        check("dis_ack", ld_ack, 1);
        check("dis_div", div_cur, 9);
        en = 1'b1;
        wait_level(1'b1, n);
        check("reen_low", n, 4);
        wait_level(1'b0, n);
        check("reen_high", n, 5);

        // Async reset between edges with a load pending.
        wait_level(1'b1, n);
        do_ld(4);
        check("pre_rst_high", clkout, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clkout", clkout, 0);
        check("arst_div", div_cur, 10000);
        check("arst_ticks", rise_tick | fall_tick, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_ack", ld_ack, 0);
        wait_level(1'b1, n);
        check("post_rst_low", n + 1, 5000);
        check("post_rst_noack", ld_ack, 0);
        check("post_rst_div", div_cur, 10000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
